// File: rtl/dff_seq_checker_if.sv
// Handshake/result bundle between a stimulus source and dff_seq_checker.
// master drives stimulus and DUT observations; slave is the checker.
interface dff_seq_checker_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             d_in;
  logic             q_in;
  logic             q_bar_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output start, stop, d_in, q_in, q_bar_in,
    input  busy, done, pass, fail, err_cnt, sample_cnt
  );

  modport slave (
    input  start, stop, d_in, q_in, q_bar_in,
    output busy, done, pass, fail, err_cnt, sample_cnt
  );
endinterface

// File: rtl/dff_seq_checker.sv
// Response monitor for single-bit storage DUTs: compares q against d delayed by LATENCY (1..4).
// Optional macro CHK_STOP_ON_FAIL_EN ends a run at the first mismatch.
module dff_seq_checker #(
  parameter int CNT_W   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  dff_seq_checker_if.slave chk
);
  typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

  localparam int               FW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [LATENCY-1:0] dly;
  logic [FW-1:0]    fill_cnt;
  logic [CNT_W-1:0] err_cnt, smp_cnt, err_nx, smp_nx;
  logic             busy_nx, done_nx, pass_nx;
  logic             busy_r, done_r, pass_r, fail_r;
  logic             fill_last, mismatch, restart;

  assign fill_last = (fill_cnt == FW'(LATENCY - 1));
  assign mismatch  = (chk.q_in != dly[LATENCY-1]) || (chk.q_bar_in != ~chk.q_in);
  assign restart   = chk.start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // start only matters when idle/done, so stop naturally wins while busy
  always_comb begin
    state_nx = state;
    err_nx   = err_cnt;
    smp_nx   = smp_cnt;
    unique case (state)
      IDLE, DONE: begin
        if (chk.start) begin
          state_nx = FILL;
          err_nx   = '0;
          smp_nx   = '0;
        end
      end
      FILL: begin
        if (chk.stop)      state_nx = DONE;
        else if (fill_last) state_nx = CHECK;
      end
      CHECK: begin
        if (smp_cnt != CNT_MAX)             smp_nx = smp_cnt + 1'b1;
        if (mismatch && err_cnt != CNT_MAX) err_nx = err_cnt + 1'b1;
        if (chk.stop) state_nx = DONE;
`ifdef CHK_STOP_ON_FAIL_EN
        if (mismatch) state_nx = DONE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy_nx = (state_nx == FILL) || (state_nx == CHECK);
    done_nx = (state_nx == DONE);
    pass_nx = done_nx && (err_nx == '0) && (smp_nx != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt  <= '0;
      smp_cnt  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      fail_r   <= 1'b0;
      fill_cnt <= '0;
      dly      <= '0;
    end else begin
      err_cnt  <= err_nx;
      smp_cnt  <= smp_nx;
      busy_r   <= busy_nx;
      done_r   <= done_nx;
      pass_r   <= pass_nx;
      fail_r   <= done_nx && !pass_nx;
      fill_cnt <= (state == FILL) ? fill_cnt + FW'(1) : '0;
      if (restart)             dly <= '0;
      else if (state != IDLE)  dly <= LATENCY'({dly, chk.d_in});
    end
  end

  assign chk.busy       = busy_r;
  assign chk.done       = done_r;
  assign chk.pass       = pass_r;
  assign chk.fail       = fail_r;
  assign chk.err_cnt    = err_cnt;
  assign chk.sample_cnt = smp_cnt;
endmodule

// File: tb/tb_dff_seq_checker.sv
// Bench for dff_seq_checker: instance A (CNT_W=4, LATENCY=1), instance B (CNT_W=8, LATENCY=2),
// both fed the same stimulus and compared every cycle against a history-based model.
module tb_dff_seq_checker;
`ifdef CHK_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] dpat;
    int         qmode;
    int         ncheck;
    int         exp_err;
    int         exp_smp;
    bit         exp_pass;
  } vec_t;

  logic clk, rst_n;
  logic start, stop, d, q, qb, q_rnd, qb_rnd, dq1, dq2;
  int   qmode;
  int   n_chk, n_fail;

  // reference model state, index 0 = instance A, 1 = instance B
  int m_lat [2];
  int m_max [2];
  bit m_run [2];
  bit m_fin [2];
  int m_age [2];
  int m_err [2];
  int m_smp [2];
  bit m_hist[2][1024];

  dff_seq_checker_if #(.CNT_W(4)) ia ();
  dff_seq_checker_if #(.CNT_W(8)) ib ();

  assign ia.start = start;  assign ib.start = start;
  assign ia.stop  = stop;   assign ib.stop  = stop;
  assign ia.d_in  = d;      assign ib.d_in  = d;
  assign ia.q_in  = q;      assign ib.q_in  = q;
  assign ia.q_bar_in = qb;  assign ib.q_bar_in = qb;

  dff_seq_checker #(.CNT_W(4), .LATENCY(1)) u_a (.clk(clk), .reset_n(rst_n), .chk(ia.slave));
  dff_seq_checker #(.CNT_W(8), .LATENCY(2)) u_b (.clk(clk), .reset_n(rst_n), .chk(ib.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ideal 1- and 2-cycle storage elements standing in for the DUT
  always @(posedge clk) begin
    dq1 <= d;
    dq2 <= dq1;
  end

  always_comb begin
    case (qmode)
      1:       q = 1'b0;
      3:       q = ~dq1;
      4:       q = dq2;
      5:       q = q_rnd;
      default: q = dq1;
    endcase
    qb = (qmode == 2) ? q : (qmode == 5) ? qb_rnd : ~q;
  end

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_fin[k] = 0; m_age[k] = 0; m_err[k] = 0; m_smp[k] = 0;
    end
  endfunction

  // expected value at an edge is the d seen LATENCY edges earlier in the run
  function automatic void model_step(int k);
    bit mis;
    if (m_run[k]) begin
      m_age[k]++;
      m_hist[k][m_age[k] % 1024] = d;
      if (m_age[k] <= m_lat[k]) begin
        if (stop) begin m_run[k] = 0; m_fin[k] = 1; end
      end else begin
        mis = (q != m_hist[k][(m_age[k] - m_lat[k]) % 1024]) || (qb != !q);
        if (m_smp[k] < m_max[k]) m_smp[k]++;
        if (mis && m_err[k] < m_max[k]) m_err[k]++;
        if (stop || (SOF && mis)) begin m_run[k] = 0; m_fin[k] = 1; end
      end
    end else if (start) begin
      m_run[k] = 1; m_fin[k] = 0; m_age[k] = 0; m_err[k] = 0; m_smp[k] = 0;
    end
  endfunction

  task automatic check_inst(int k);
    logic [19:0] act, exp;
    logic        mp;
    if (k == 0)
      act = {ia.busy, ia.done, ia.pass, ia.fail, 4'd0, ia.err_cnt, 4'd0, ia.sample_cnt};
    else
      act = {ib.busy, ib.done, ib.pass, ib.fail, ib.err_cnt, ib.sample_cnt};
    mp  = m_fin[k] && (m_err[k] == 0) && (m_smp[k] != 0);
    exp = {m_run[k], m_fin[k], mp, m_fin[k] && !mp, 8'(m_err[k]), 8'(m_smp[k])};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL model_inst%0d t=%0t: got %05h expected %05h", k, $time, act, exp);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs are driven 2 units after posedge; model samples them just before the next edge
  task automatic tick();
    #1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #2;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_inst(0);
    check_inst(1);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkv(string n, logic [7:0] p, int qm, int nc, int e, int s, bit ps);
    vec_t v;
    v.name = n; v.dpat = p; v.qmode = qm; v.ncheck = nc;
    v.exp_err = e; v.exp_smp = s; v.exp_pass = ps;
    return v;
  endfunction

  // start edge, one FILL edge, ncheck compares, then a compared stop edge
  task automatic run_vec(input vec_t v);
    logic [7:0] pat;
    pat   = v.dpat;
    qmode = v.qmode;
    d = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i <= v.ncheck; i++) begin
      d = (i < 8) ? pat[7 - i] : 1'b0;
      tick();
    end
    stop = 1'b1; d = 1'b0; tick(); stop = 1'b0;
    chk({v.name, "_done"}, int'(ia.done), 1);
    chk({v.name, "_err"},  int'(ia.err_cnt), v.exp_err);
    chk({v.name, "_smp"},  int'(ia.sample_cnt), v.exp_smp);
    chk({v.name, "_pass"}, int'(ia.pass), int'(v.exp_pass));
    chk({v.name, "_fail"}, int'(ia.fail), int'(!v.exp_pass));
  endtask

  initial begin
    vec_t vt[4];
    vt[0] = mkv("ideal_dff", 8'b10101100, 0, 8,  0,           9,           1'b1);
    vt[1] = mkv("q_stuck0",  8'b10101010, 1, 8,  SOF ? 1 : 4,  SOF ? 1 : 9,  1'b0);
    vt[2] = mkv("qbar_eq_q", 8'b11001010, 2, 4,  SOF ? 1 : 5,  SOF ? 1 : 5,  1'b0);
    vt[3] = mkv("saturate",  8'b01101001, 3, 19, SOF ? 1 : 15, SOF ? 1 : 15, 1'b0);

    m_lat[0] = 1; m_max[0] = 15;
    m_lat[1] = 2; m_max[1] = 255;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; d = 1'b0; qmode = 0;
    q_rnd = 1'b0; qb_rnd = 1'b1;
    model_reset();

    #3;
    check_inst(0);
    check_inst(1);
    chk("reset_done_a", int'(ia.done), 0);
    chk("reset_pass_b", int'(ib.pass), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // start+stop together from IDLE, then stop on second FILL edge of the LATENCY=2 instance
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("ss_busy_b", int'(ib.busy), 1);
    chk("ss_done_b", int'(ib.done), 0);
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("fill_stop_done_b", int'(ib.done), 1);
    chk("fill_stop_smp_b",  int'(ib.sample_cnt), 0);
    chk("fill_stop_pass_b", int'(ib.pass), 0);
    chk("fill_stop_fail_b", int'(ib.fail), 1);

    foreach (vt[i]) run_vec(vt[i]);

    // reset in the middle of a failing run
    do_reset();
    qmode = 1; d = 1'b1; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
`ifndef CHK_STOP_ON_FAIL_EN
    chk("pre_rst_err_a", int'(ia.err_cnt), 3);
`endif
    #1;
    do_reset();
    chk("mid_rst_done_a", int'(ia.done), 0);
    chk("mid_rst_busy_a", int'(ia.busy), 0);
    chk("mid_rst_err_a",  int'(ia.err_cnt), 0);
    chk("mid_rst_smp_a",  int'(ia.sample_cnt), 0);

    // wrong q only on the third compared edge
    qmode = 0; d = 1'($urandom); start = 1'b1; tick(); start = 1'b0;
    d = 1'($urandom); tick();
    d = 1'($urandom); tick();
    d = 1'($urandom); tick();
    qmode = 3; d = 1'($urandom); tick();
    qmode = 0;
`ifdef CHK_STOP_ON_FAIL_EN
    chk("sof_done_a", int'(ia.done), 1);
`else
    chk("cont_busy_a", int'(ia.busy), 1);
`endif
    chk("third_err_a", int'(ia.err_cnt), 1);
    chk("third_smp_a", int'(ia.sample_cnt), 3);
    stop = 1'b1; tick(); stop = 1'b0;

    // random traffic: mostly-correct LATENCY=2 responses with sparse q/q_bar faults
    qmode = 5;
    for (int c = 0; c < 2000; c++) begin
      d      = 1'($urandom);
      q_rnd  = ($urandom_range(0, 5) == 0) ? 1'($urandom) : dq2;
      qb_rnd = ($urandom_range(0, 9) == 0) ? q_rnd : ~q_rnd;
      start  = ($urandom_range(0, 7) == 0);
      stop   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      tick();
    end
    start = 1'b0; stop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dff_seq_checker.md
Name: dff_seq_checker

Overview:
Self-checking response monitor for single-bit storage elements such as the D flip-flop and latch.
- Samples the stimulus bit driven into a device under test (DUT) and the DUT's q/q_bar outputs on every rising clk.
- Compares q against a delayed copy of the stimulus and counts mismatches.
- Reports pass/fail, so benches in this collection are scored in hardware rather than by waveform inspection.
- Sits beside the DUT, clocked by the same clk.

Parameters:
- CNT_W, 8: width of the error and sample counters (saturating).
- LATENCY, 1: clk cycles between a d sample and the q it produces; legal range 1..4.

Ports:
- clk  input  1  rising-edge clock, same clock as the DUT.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a check run.
- stop  input  1  one-cycle pulse; ends a check run.
- d_in  input  1  stimulus bit applied to the DUT d.
- q_in  input  1  DUT q.
- q_bar_in  input  1  DUT q_bar.
- busy  output  1  high in FILL or CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done=1.
- fail  output  1  valid when done=1; always the inverse of pass while done=1.
- err_cnt  output  CNT_W  mismatch count.
- sample_cnt  output  CNT_W  number of compared cycles.

Behaviour:
Reset (reset_n=0, asynchronous):
- state=IDLE.
- Delay line, err_cnt and sample_cnt = 0.
- busy=0, done=0, pass=0, fail=0.

Delay line:
- LATENCY-stage shift register of d_in.
- Shifts every clk in all states except IDLE.
- Stage 0 holds d_in of the previous edge; the expected value is stage LATENCY-1.

States and transitions:
- IDLE: on start, clear both counters and the delay line, then go to FILL.
- FILL: wait LATENCY edges with no comparisons, then go to CHECK. stop during FILL goes to DONE with sample_cnt=0.
- CHECK: at each edge, sample_cnt += 1 (saturates at 2^CNT_W-1). A mismatch is (q_in != expected) OR (q_bar_in != ~q_in); each mismatch sets err_cnt += 1 (saturates). stop goes to DONE; the cycle carrying stop is still compared.
- DONE: counters frozen. pass = (err_cnt==0) && (sample_cnt!=0); fail = ~pass. start clears counters and goes to FILL.

Simultaneous start and stop:
- In IDLE or DONE, start wins.
- In FILL or CHECK, stop wins.

Other rules:
- start while busy is ignored.
- Outputs are registered; all state/counter updates become visible one edge after the causing sample.
- Saturated counters hold their value; they do not wrap.
- Reset mid-run aborts to IDLE immediately; no partial result is retained.
- Inputs X/Z are not handled; the bench must drive known values.

Optional Feature:
Macro: CHK_STOP_ON_FAIL_EN
- Defined: the first mismatch in CHECK moves to DONE at that same edge. err_cnt=1, and sample_cnt includes the failing sample, so it equals the index of the first failure plus 1.
- Undefined: the run continues to stop and counts all mismatches.

Test Plan:
1. Ideal DFF model, LATENCY=1, d pattern 1,0,1,0,1,1,0,0 over 8 cycles, then stop -> done=1, pass=1, err_cnt=0, sample_cnt=9.
2. q_in forced to 0 while d alternates 1/0 for 8 cycles -> err_cnt=4, fail=1.
3. q_bar_in tied equal to q_in with a correct q_in, 5 checked cycles -> err_cnt=5, fail=1.
4. CNT_W=4, q forced wrong for 20 cycles -> err_cnt=15 and sample_cnt=15 (both saturated, no wrap).
5. start and stop asserted in the same cycle from IDLE -> enters FILL. stop on the second cycle of FILL with LATENCY=2 -> done=1, sample_cnt=0, pass=0.
6. reset_n pulsed low mid-CHECK with err_cnt=3 -> counters 0, state IDLE, done=0 immediately. With CHK_STOP_ON_FAIL_EN defined and a wrong q on the 3rd compared cycle -> done one edge later, err_cnt=1, sample_cnt=3.
